hpi_access_ctrl: RTL and testbench
==================================

HPI_ACCESS_CTRL -- requirements
Module: hpi_access_ctrl

Interface
REQ-001 Parameter PULSE_CYCLES, default 4, strobe-low width in Clk cycles; legal range 1..15.
REQ-002 Parameter RECOVER_CYCLES, default 2, strobe-high recovery in Clk cycles; legal range 2..15.
REQ-003 Clk  input  1  clock; all state updates on the rising edge.
REQ-004 Reset  input  1  reset; asynchronous, active-high.
REQ-005 req_valid  input  1  a host request is presented.
REQ-006 req_ready  output  1  controller accepts a request this cycle.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  16  CY7C67200 memory word address; bit 0 is ignored and treated as 0.
REQ-009 req_wdata  input  16  write data.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  16  read data; valid while rsp_valid=1.
REQ-012 from_sw_address  output  2  HPI port select to the HPI I/O stage.
REQ-013 from_sw_data_out  output  16  write data to the HPI I/O stage.
REQ-014 from_sw_r, from_sw_w, from_sw_cs  output  1 each  active-low strobes to the HPI I/O stage.
REQ-015 from_sw_data_in  input  16  registered read data from the HPI I/O stage.

Function
REQ-016 States: IDLE, A_SETUP, A_STROBE, A_RECOV, D_SETUP, D_STROBE, D_RECOV, DONE.
REQ-017 req_ready is 1 only in IDLE; acceptance occurs on an edge where req_valid=1 and req_ready=1.
REQ-018 On acceptance, req_write, the aligned req_addr and req_wdata are latched; later input changes are ignored until DONE.
REQ-019 On acceptance: if addr_valid=1 and the latched address equals next_addr, go to D_SETUP; otherwise go to A_SETUP.
REQ-020 Address phase: from_sw_address=2'b10 (HPI_ADDRESS) and from_sw_data_out=latched address for A_SETUP through A_RECOV.
REQ-021 Data phase: from_sw_address=2'b00 (HPI_DATA); for writes, from_sw_data_out=latched wdata for D_SETUP through D_RECOV.
REQ-022 Each SETUP state lasts 1 cycle with all strobes high.
REQ-023 In A_STROBE, from_sw_cs=0 and from_sw_w=0 for exactly PULSE_CYCLES cycles.
REQ-024 In D_STROBE, from_sw_cs=0 and either from_sw_w=0 (write) or from_sw_r=0 (read) for exactly PULSE_CYCLES cycles.
REQ-025 Each RECOV state lasts RECOVER_CYCLES cycles with all strobes high; from_sw_r and from_sw_w are never low together.
REQ-026 Read capture: rsp_rdata <= from_sw_data_in on the second D_RECOV cycle, which compensates for the two register stages of the I/O block.
REQ-027 rsp_rdata holds its value until the next read capture; on writes it is unchanged.
REQ-028 DONE lasts 1 cycle, rsp_valid=1 in DONE only, then the FSM returns to IDLE.
REQ-029 Latency from acceptance edge to rsp_valid: 2*(1+PULSE_CYCLES+RECOVER_CYCLES) cycles with an address phase, (1+PULSE_CYCLES+RECOVER_CYCLES) cycles without.
REQ-030 After each data phase: next_addr <= latched address + 2 (16-bit wrap, 16'hFFFE -> 16'h0000) and addr_valid <= 1.
REQ-031 Back-to-back operation: a request held during DONE is accepted in the following IDLE cycle; there is no combinational path from req_valid to req_ready.

Reset
REQ-032 Reset forces: state=IDLE; from_sw_r=from_sw_w=from_sw_cs=1; from_sw_address=2'b00; from_sw_data_out=0; rsp_valid=0; rsp_rdata=0; addr_valid=0; next_addr=0; timer=0.
REQ-033 Reset asserted mid-transaction aborts it immediately with no rsp_valid, and the next request performs a full address phase.

Structure
REQ-034 Shared package hpi_pkg: state enum; port constants HPI_DATA=2'b00, HPI_MAILBOX=2'b01, HPI_ADDRESS=2'b10, HPI_STATUS=2'b11.
REQ-035 Sub-module hpi_strobe_timer: 4-bit load/decrement counter with done flag; it is instantiated once and shared by all timed states.
REQ-036 All outputs are registered.

Verification
REQ-037 Write 0x1000<=0xBEEF from reset -> address strobe then data strobe, each 4 cycles low; port 2 with data 0x1000, then port 0 with data 0xBEEF; rsp_valid 14 cycles after acceptance.
REQ-038 Read 0x1002 right after REQ-037 -> no address phase; from_sw_r low for 4 cycles; the model drives 0x1234, so rsp_rdata=0x1234 and rsp_valid arrives 7 cycles after acceptance.
REQ-039 Read 0x2000 after REQ-038 -> full address phase because the address does not match next_addr 0x1004.
REQ-040 Write 0xFFFE then read 0x0000 -> wrap: the read skips the address phase.
REQ-041 Reset asserted during D_STROBE of a read -> strobes high asynchronously and no rsp_valid; the next access to the same address performs an address phase.
REQ-042 req_valid held high continuously with PULSE_CYCLES=1 and RECOVER_CYCLES=2 -> one acceptance per IDLE visit; r/w never low simultaneously; minimum strobe-high gap of 3 cycles between accesses.

Source files
------------

// File: rtl/hpi_pkg.sv
// Shared definitions for the CY7C67200 HPI access controller: FSM states,
// HPI port selects and small address helpers.
package hpi_pkg;

   // Access sequencer states
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      A_SETUP  = 3'd1,
      A_STROBE = 3'd2,
      A_RECOV  = 3'd3,
      D_SETUP  = 3'd4,
      D_STROBE = 3'd5,
      D_RECOV  = 3'd6,
      DONE     = 3'd7
   } hpi_state_e;

   // HPI port selects driven on from_sw_address
   localparam logic [1:0] HPI_DATA    = 2'b00;
   localparam logic [1:0] HPI_MAILBOX = 2'b01;
   localparam logic [1:0] HPI_ADDRESS = 2'b10;
   localparam logic [1:0] HPI_STATUS  = 2'b11;

   // Width of the shared strobe timer
   localparam int unsigned TIMER_W = 4;

   // CY7C67200 memory is word addressed on even byte addresses
   function automatic logic [15:0] hpi_align(input logic [15:0] addr);
      return addr & 16'hFFFE;
   endfunction

   // Address the chip's auto-increment points at after a data access
   function automatic logic [15:0] hpi_next_word(input logic [15:0] addr);
      return addr + 16'd2;
   endfunction

endpackage

// File: rtl/hpi_strobe_timer.sv
// Load/decrement down-counter shared by every timed state of the HPI
// sequencer. done_o is high while the count is zero.
module hpi_strobe_timer
   import hpi_pkg::*;
(
   input  logic               Clk,
   input  logic               Reset,
   input  logic               load_i,
   input  logic [TIMER_W-1:0] load_val_i,
   input  logic               dec_i,
   output logic [TIMER_W-1:0] count_o,
   output logic               done_o
);

   logic [TIMER_W-1:0] cnt_q;
   logic [TIMER_W-1:0] cnt_d;

   // Next count: load wins over decrement, decrement saturates at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;
   assign done_o  = (cnt_q == 4'd0);

endmodule

// File: rtl/hpi_access_ctrl.sv
// Host-side access sequencer for the CY7C67200 HPI. Turns one request into
// an optional address-port write followed by a data-port read or write, with
// programmable strobe width and recovery. The address phase is skipped when
// the request hits the address the chip's auto-increment already points at.
module hpi_access_ctrl
   import hpi_pkg::*;
#(
   parameter int unsigned PULSE_CYCLES   = 4,
   parameter int unsigned RECOVER_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic [1:0]  from_sw_address,
   output logic [15:0] from_sw_data_out,
   output logic        from_sw_r,
   output logic        from_sw_w,
   output logic        from_sw_cs,
   input  logic [15:0] from_sw_data_in
);

   // Timer reload values; the timer counts down to zero inclusive
   localparam logic [TIMER_W-1:0] PULSE_LD   = TIMER_W'(PULSE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] RECOV_LD   = TIMER_W'(RECOVER_CYCLES - 1);
   // Count value seen during the second D_RECOV cycle: read data has then
   // crossed both register stages of the I/O block
   localparam logic [TIMER_W-1:0] CAPTURE_AT = TIMER_W'(RECOVER_CYCLES - 2);

   hpi_state_e state_q, state_d;

   logic        wr_q, wr_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] next_addr_q, next_addr_d;
   logic        addr_valid_q, addr_valid_d;

   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [15:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]  port_q, port_d;
   logic [15:0] dout_q, dout_d;
   logic        r_q, r_d;
   logic        w_q, w_d;
   logic        cs_q, cs_d;

   logic               tmr_load;
   logic [TIMER_W-1:0] tmr_load_val;
   logic               tmr_dec;
   logic [TIMER_W-1:0] tmr_count;
   logic               tmr_done;
   logic               capture;

   hpi_strobe_timer u_timer (
      .Clk        (Clk),
      .Reset      (Reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .dec_i      (tmr_dec),
      .count_o    (tmr_count),
      .done_o     (tmr_done)
   );

   // Next-state, request latching, timer control and address tracking
   always_comb begin
      state_d      = state_q;
      wr_d         = wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      next_addr_d  = next_addr_q;
      addr_valid_d = addr_valid_q;
      tmr_load     = 1'b0;
      tmr_load_val = 4'd0;
      tmr_dec      = 1'b0;
      capture      = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               wr_d    = req_write;
               addr_d  = hpi_align(req_addr);
               wdata_d = req_wdata;
               if (addr_valid_q && (hpi_align(req_addr) == next_addr_q)) begin
                  state_d = D_SETUP;
               end else begin
                  state_d = A_SETUP;
               end
            end else begin
               state_d = IDLE;
            end
         end
         A_SETUP: begin
            state_d      = A_STROBE;
            tmr_load     = 1'b1;
            tmr_load_val = PULSE_LD;
         end
         A_STROBE: begin
            if (tmr_done) begin
               state_d      = A_RECOV;
               tmr_load     = 1'b1;
               tmr_load_val = RECOV_LD;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         A_RECOV: begin
            if (tmr_done) begin
               state_d = D_SETUP;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         D_SETUP: begin
            state_d      = D_STROBE;
            tmr_load     = 1'b1;
            tmr_load_val = PULSE_LD;
         end
         D_STROBE: begin
            if (tmr_done) begin
               state_d      = D_RECOV;
               tmr_load     = 1'b1;
               tmr_load_val = RECOV_LD;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         D_RECOV: begin
            capture = !wr_q && (tmr_count == CAPTURE_AT);
            if (tmr_done) begin
               state_d      = DONE;
               next_addr_d  = hpi_next_word(addr_q);
               addr_valid_d = 1'b1;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode from the upcoming state so every output is a flop aligned with it
   always_comb begin
      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == DONE);
      rsp_rdata_d = capture ? from_sw_data_in : rsp_rdata_q;
      port_d      = port_q;
      dout_d      = dout_q;
      r_d         = 1'b1;
      w_d         = 1'b1;
      cs_d        = 1'b1;
      case (state_d)
         A_SETUP, A_RECOV: begin
            port_d = HPI_ADDRESS;
            dout_d = addr_d;
         end
         A_STROBE: begin
            port_d = HPI_ADDRESS;
            dout_d = addr_d;
            cs_d   = 1'b0;
            w_d    = 1'b0;
         end
         D_SETUP, D_RECOV: begin
            port_d = HPI_DATA;
            if (wr_d) begin
               dout_d = wdata_d;
            end else begin
               dout_d = dout_q;
            end
         end
         D_STROBE: begin
            port_d = HPI_DATA;
            cs_d   = 1'b0;
            if (wr_d) begin
               dout_d = wdata_d;
               w_d    = 1'b0;
            end else begin
               r_d    = 1'b0;
            end
         end
         default: begin
            port_d = port_q;
            dout_d = dout_q;
         end
      endcase
   end

   // State, latched request and output registers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= IDLE;
         wr_q         <= 1'b0;
         addr_q       <= 16'h0000;
         wdata_q      <= 16'h0000;
         next_addr_q  <= 16'h0000;
         addr_valid_q <= 1'b0;
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= 16'h0000;
         port_q       <= 2'b00;
         dout_q       <= 16'h0000;
         r_q          <= 1'b1;
         w_q          <= 1'b1;
         cs_q         <= 1'b1;
      end else begin
         state_q      <= state_d;
         wr_q         <= wr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         next_addr_q  <= next_addr_d;
         addr_valid_q <= addr_valid_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         port_q       <= port_d;
         dout_q       <= dout_d;
         r_q          <= r_d;
         w_q          <= w_d;
         cs_q         <= cs_d;
      end
   end

   assign req_ready        = req_ready_q;
   assign rsp_valid        = rsp_valid_q;
   assign rsp_rdata        = rsp_rdata_q;
   assign from_sw_address  = port_q;
   assign from_sw_data_out = dout_q;
   assign from_sw_r        = r_q;
   assign from_sw_w        = w_q;
   assign from_sw_cs       = cs_q;

endmodule

// File: tb/tb_hpi_access_ctrl.sv
// Directed bench for hpi_access_ctrl: default timing instance for the
// functional scenarios, fast-timing instance for back-to-back requests.
module tb_hpi_access_ctrl;

   logic        Clk = 1'b0;
   logic        Reset;
   int          total = 0;
   int          bad = 0;

   // Default-timing instance (PULSE 4, RECOVER 2)
   logic        req_valid, req_ready, req_write, rsp_valid;
   logic [15:0] req_addr, req_wdata, rsp_rdata;
   logic [1:0]  from_sw_address;
   logic [15:0] from_sw_data_out, from_sw_data_in;
   logic        from_sw_r, from_sw_w, from_sw_cs;

   // Fast-timing instance (PULSE 1, RECOVER 2)
   logic        req_valid_b, req_ready_b, req_write_b, rsp_valid_b;
   logic [15:0] req_addr_b, req_wdata_b, rsp_rdata_b;
   logic [1:0]  from_sw_address_b;
   logic [15:0] from_sw_data_out_b;
   logic [15:0] from_sw_data_in_b = 16'h0000;
   logic        from_sw_r_b, from_sw_w_b, from_sw_cs_b;

   always #5 Clk = ~Clk;

   hpi_access_ctrl dut (
      .Clk(Clk), .Reset(Reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .from_sw_address(from_sw_address), .from_sw_data_out(from_sw_data_out),
      .from_sw_r(from_sw_r), .from_sw_w(from_sw_w), .from_sw_cs(from_sw_cs),
      .from_sw_data_in(from_sw_data_in)
   );

   hpi_access_ctrl #(.PULSE_CYCLES(1), .RECOVER_CYCLES(2)) dut_b (
      .Clk(Clk), .Reset(Reset),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
      .req_addr(req_addr_b), .req_wdata(req_wdata_b),
      .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
      .from_sw_address(from_sw_address_b), .from_sw_data_out(from_sw_data_out_b),
      .from_sw_r(from_sw_r_b), .from_sw_w(from_sw_w_b), .from_sw_cs(from_sw_cs_b),
      .from_sw_data_in(from_sw_data_in_b)
   );

   // HPI I/O stage model: two register stages from read strobe to data
   logic [15:0] model_rdata;
   logic        rd_s1;
   always @(posedge Clk) begin
      rd_s1 <= !from_sw_r && !from_sw_cs;
      if (rd_s1) from_sw_data_in <= model_rdata;
   end

   // Strobe pulse logger for the default instance
   int          log_n = 0;
   logic [1:0]  log_port [0:31];
   logic [15:0] log_data [0:31];
   logic        log_isw  [0:31];
   int          log_len  [0:31];
   int          overlap = 0;
   logic        in_p = 1'b0;
   int          plen = 0;
   logic [1:0]  pport;
   logic [15:0] pdata;
   logic        pisw;
   always @(negedge Clk) begin
      if (!from_sw_r && !from_sw_w) overlap++;
      if (!from_sw_cs) begin
         if (!in_p) begin
            in_p = 1'b1; plen = 0;
            pport = from_sw_address; pdata = from_sw_data_out; pisw = !from_sw_w;
         end
         plen++;
      end else if (in_p) begin
         in_p = 1'b0;
         if (log_n < 32) begin
            log_port[log_n] = pport; log_data[log_n] = pdata;
            log_isw[log_n] = pisw; log_len[log_n] = plen;
         end
         log_n++;
      end
   end

   // Monitor for the fast instance: acceptances, responses, overlap, strobe gaps
   int   acc_b = 0, rsp_b = 0, overlap_b = 0, gap_min_b = 1000, gap_cur_b = 0;
   logic seen_b = 1'b0;
   always @(negedge Clk) begin
      if (req_valid_b && req_ready_b) acc_b++;
      if (rsp_valid_b) rsp_b++;
      if (!from_sw_r_b && !from_sw_w_b) overlap_b++;
      if (!from_sw_cs_b) begin
         if (seen_b && gap_cur_b > 0 && gap_cur_b < gap_min_b) gap_min_b = gap_cur_b;
         seen_b = 1'b1; gap_cur_b = 0;
      end else begin
         gap_cur_b++;
      end
   end

   // One request on the default instance; starts and ends on a falling edge
   task automatic run_access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                             output int lat, output logic [15:0] rdata, output int base);
      int n;
      base = log_n;
      req_write = wr; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 100) begin @(negedge Clk); n++; end
      total++;
      if (req_ready !== 1'b1) begin bad++; $display("FAIL accept_wait: ready=%b after %0d cycles", req_ready, n); end
      @(posedge Clk); #1;
      // Scramble inputs to show the request was latched
      req_valid = 1'b0; req_write = ~wr; req_addr = addr ^ 16'h5AA4; req_wdata = ~wdata;
      lat = 0;
      while (!rsp_valid && lat < 100) begin @(negedge Clk); if (!rsp_valid) lat++; end
      rdata = rsp_rdata;
      @(negedge Clk);
      total++;
      if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rsp_one_cycle: rsp_valid=%b want 0", rsp_valid); end
   endtask

   task automatic test_reset;
      Reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
      req_valid_b = 1'b0; req_write_b = 1'b0; req_addr_b = 16'h0; req_wdata_b = 16'h0;
      model_rdata = 16'h0000;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      total++; if ({from_sw_r, from_sw_w, from_sw_cs} !== 3'b111) begin bad++; $display("FAIL rst_strobes: got %b want 111", {from_sw_r, from_sw_w, from_sw_cs}); end
      total++; if (from_sw_address !== 2'b00) begin bad++; $display("FAIL rst_port: got %b want 00", from_sw_address); end
      total++; if (from_sw_data_out !== 16'h0000) begin bad++; $display("FAIL rst_dout: got %h want 0000", from_sw_data_out); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
      total++; if (rsp_rdata !== 16'h0000) begin bad++; $display("FAIL rst_rdata: got %h want 0000", rsp_rdata); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_write_first;
      int lat, b; logic [15:0] rd;
      run_access(1'b1, 16'h1000, 16'hBEEF, lat, rd, b);
      total++; if (lat != 14) begin bad++; $display("FAIL wr_latency: got %0d want 14", lat); end
      total++; if (log_n - b != 2) begin bad++; $display("FAIL wr_pulses: got %0d want 2", log_n - b); end
      total++; if ({log_port[b], log_data[b], log_isw[b]} !== {2'b10, 16'h1000, 1'b1} || log_len[b] != 4) begin
         bad++; $display("FAIL wr_addr_pulse: port=%b data=%h w=%b len=%0d want 10 1000 1 4", log_port[b], log_data[b], log_isw[b], log_len[b]); end
      total++; if ({log_port[b+1], log_data[b+1], log_isw[b+1]} !== {2'b00, 16'hBEEF, 1'b1} || log_len[b+1] != 4) begin
         bad++; $display("FAIL wr_data_pulse: port=%b data=%h w=%b len=%0d want 00 beef 1 4", log_port[b+1], log_data[b+1], log_isw[b+1], log_len[b+1]); end
      total++; if (rd !== 16'h0000) begin bad++; $display("FAIL wr_rdata_kept: got %h want 0000", rd); end
   endtask

   task automatic test_read_seq;
      int lat, b; logic [15:0] rd;
      model_rdata = 16'h1234;
      run_access(1'b0, 16'h1002, 16'h0000, lat, rd, b);
      total++; if (lat != 7) begin bad++; $display("FAIL rd_seq_latency: got %0d want 7", lat); end
      total++; if (log_n - b != 1) begin bad++; $display("FAIL rd_seq_pulses: got %0d want 1", log_n - b); end
      total++; if ({log_port[b], log_isw[b]} !== {2'b00, 1'b0} || log_len[b] != 4) begin
         bad++; $display("FAIL rd_seq_pulse: port=%b w=%b len=%0d want 00 0 4", log_port[b], log_isw[b], log_len[b]); end
      total++; if (rd !== 16'h1234) begin bad++; $display("FAIL rd_seq_data: got %h want 1234", rd); end
   endtask

   task automatic test_read_miss;
      int lat, b; logic [15:0] rd;
      model_rdata = 16'h5A5A;
      run_access(1'b0, 16'h2001, 16'h0000, lat, rd, b);
      total++; if (lat != 14) begin bad++; $display("FAIL rd_miss_latency: got %0d want 14", lat); end
      total++; if (log_n - b != 2 || {log_port[b], log_data[b]} !== {2'b10, 16'h2000}) begin
         bad++; $display("FAIL rd_miss_addr: n=%0d port=%b data=%h want 2 10 2000", log_n - b, log_port[b], log_data[b]); end
      total++; if (rd !== 16'h5A5A) begin bad++; $display("FAIL rd_miss_data: got %h want 5a5a", rd); end
   endtask

   task automatic test_wrap;
      int lat, b; logic [15:0] rd;
      run_access(1'b1, 16'hFFFE, 16'h0F0F, lat, rd, b);
      total++; if (lat != 14) begin bad++; $display("FAIL wrap_wr_latency: got %0d want 14", lat); end
      total++; if (rd !== 16'h5A5A) begin bad++; $display("FAIL wrap_wr_rdata_kept: got %h want 5a5a", rd); end
      model_rdata = 16'hC3C3;
      run_access(1'b0, 16'h0000, 16'h0000, lat, rd, b);
      total++; if (lat != 7) begin bad++; $display("FAIL wrap_rd_latency: got %0d want 7", lat); end
      total++; if (rd !== 16'hC3C3) begin bad++; $display("FAIL wrap_rd_data: got %h want c3c3", rd); end
   endtask

   task automatic test_reset_abort;
      int n, lat, b; logic [15:0] rd; logic saw;
      model_rdata = 16'h7777;
      req_write = 1'b0; req_addr = 16'h0002; req_valid = 1'b1;
      @(posedge Clk); #1 req_valid = 1'b0;
      n = 0;
      while (from_sw_r && n < 50) begin @(negedge Clk); n++; end
      total++; if (from_sw_r !== 1'b0) begin bad++; $display("FAIL abort_reach_strobe: r=%b want 0", from_sw_r); end
      #2 Reset = 1'b1;
      #1;
      total++; if ({from_sw_r, from_sw_w, from_sw_cs} !== 3'b111) begin bad++; $display("FAIL abort_strobes: got %b want 111", {from_sw_r, from_sw_w, from_sw_cs}); end
      saw = 1'b0;
      repeat (3) begin @(negedge Clk); if (rsp_valid !== 1'b0) saw = 1'b1; end
      Reset = 1'b0;
      repeat (12) begin @(negedge Clk); if (rsp_valid !== 1'b0) saw = 1'b1; end
      total++; if (saw !== 1'b0) begin bad++; $display("FAIL abort_no_rsp: saw rsp_valid=%b want 0", saw); end
      total++; if (rsp_rdata !== 16'h0000) begin bad++; $display("FAIL abort_rdata_cleared: got %h want 0000", rsp_rdata); end
      model_rdata = 16'h8888;
      run_access(1'b0, 16'h0002, 16'h0000, lat, rd, b);
      total++; if (lat != 14) begin bad++; $display("FAIL abort_next_latency: got %0d want 14", lat); end
      total++; if (rd !== 16'h8888) begin bad++; $display("FAIL abort_next_data: got %h want 8888", rd); end
      total++; if (overlap != 0) begin bad++; $display("FAIL rw_overlap: got %0d want 0", overlap); end
   endtask

   task automatic test_back_to_back;
      req_write_b = 1'b1; req_addr_b = 16'h0040; req_wdata_b = 16'h00A5;
      @(posedge Clk); #1 req_valid_b = 1'b1;
      repeat (60) @(posedge Clk);
      #1 req_valid_b = 1'b0;
      repeat (20) @(negedge Clk);
      total++; if (acc_b != 6) begin bad++; $display("FAIL b2b_accepts: got %0d want 6", acc_b); end
      total++; if (rsp_b != 6) begin bad++; $display("FAIL b2b_responses: got %0d want 6", rsp_b); end
      total++; if (overlap_b != 0) begin bad++; $display("FAIL b2b_rw_overlap: got %0d want 0", overlap_b); end
      total++; if (gap_min_b != 3) begin bad++; $display("FAIL b2b_min_gap: got %0d want 3", gap_min_b); end
   endtask

   initial begin
      test_reset();
      test_write_first();
      test_read_seq();
      test_read_miss();
      test_wrap();
      test_reset_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
